pellet_tracker: RTL and testbench



---
 rtl/pellet_tracker.sv | 192 +++++++++++++++++++
 tb/tb_pellet_tracker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pellet_tracker.sv
// Pellet map for the maze: loads cells from the maze ROM, clears pellets under the sprite centre,
// keeps score, counts remaining pellets and flags level completion; registered read port for the renderer.
module pellet_tracker #(
   parameter int GRID_X0    = 208,
   parameter int GRID_Y0    = 16,
   parameter int CELL_SHIFT = 3,
   parameter int COLS       = 28,
   parameter int ROWS       = 31,
   parameter int PELLET_PTS = 10,
   parameter int POWER_PTS  = 50
) (
   input  logic        frame_clk,
   input  logic        Reset_n,
   input  logic [9:0]  BallX,
   input  logic [9:0]  BallY,
   input  logic        Restart,
   output logic [9:0]  Rom_Addr,
   input  logic [1:0]  Rom_Data,
   input  logic [9:0]  Rd_Addr,
   output logic [1:0]  Rd_Data,
   output logic [15:0] Score,
   output logic [9:0]  Pellets_Left,
   output logic        Eat_Pulse,
   output logic        Power_Pulse,
   output logic        Level_Clear,
   output logic        Ready
);

   localparam logic [9:0] N10    = 10'(COLS * ROWS);
   localparam logic [9:0] COLS10 = 10'(COLS);
   localparam logic [9:0] ROWS10 = 10'(ROWS);
   localparam logic [9:0] X0_10  = 10'(GRID_X0);
   localparam logic [9:0] Y0_10  = 10'(GRID_Y0);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t      state_q, state_d;
   logic [9:0]  a_q, a_d;
   logic        ld_vld_q, ld_vld_d;
   logic [9:0]  ld_addr_q, ld_addr_d;
   logic        s1_vld_q, s1_vld_d;
   logic [9:0]  s1_addr_q, s1_addr_d;
   logic        s2_vld_q, s2_vld_d;
   logic [9:0]  s2_addr_q, s2_addr_d;
   logic [1:0]  s2_cell_q, s2_cell_d;
   logic [15:0] score_q, score_d;
   logic [9:0]  left_q, left_d;
   logic        eat_q, eat_d;
   logic        pow_q, pow_d;
   logic        clr_q, clr_d;
   logic [1:0]  rd_q, rd_d;

   logic [1:0]  mem [0:COLS*ROWS-1];
   logic        we;
   logic [9:0]  waddr;
   logic [1:0]  wdata;

   logic [9:0]  dx, dy, col, row, pos_addr;
   logic        on_grid, clearing;
   logic [16:0] sum;

   always_comb begin
      dx       = BallX - X0_10;
      dy       = BallY - Y0_10;
      col      = dx >> CELL_SHIFT;
      row      = dy >> CELL_SHIFT;
      on_grid  = (BallX >= X0_10) && (BallY >= Y0_10) && (col < COLS10) && (row < ROWS10);
      pos_addr = row * COLS10 + col;
      clearing = s2_vld_q && (s2_cell_q != 2'd0);
      sum      = {1'b0, score_q} + ((s2_cell_q == 2'd2) ? 17'(POWER_PTS) : 17'(PELLET_PTS));
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      ld_vld_d  = 1'b0;
      ld_addr_d = a_q;
      s1_vld_d  = 1'b0;
      s1_addr_d = '0;
      s2_vld_d  = 1'b0;
      s2_addr_d = s1_addr_q;
      // a cell S2 is clearing right now must not be read back as full
      s2_cell_d = (clearing && (s2_addr_q == s1_addr_q)) ? 2'd0 : mem[s1_addr_q];
      score_d   = score_q;
      left_d    = left_q;
      eat_d     = 1'b0;
      pow_d     = 1'b0;
      clr_d     = clr_q;
      we        = 1'b0;
      waddr     = ld_addr_q;
      wdata     = (Rom_Data == 2'd3) ? 2'd0 : Rom_Data;
      rd_d      = (Rd_Addr < N10) ? mem[Rd_Addr] : 2'd0;

      case (state_q)
         S_INIT: begin
            if (ld_vld_q) begin
               we = 1'b1;
               if (Rom_Data == 2'd1 || Rom_Data == 2'd2) left_d = left_q + 10'd1;
            end
            if (a_q < N10) begin
               ld_vld_d = 1'b1;
               a_d      = a_q + 10'd1;
            end else begin
               state_d = S_RUN;
            end
            if (Restart) begin
               a_d      = '0;
               ld_vld_d = 1'b0;
               left_d   = '0;
               state_d  = S_INIT;
            end
         end
         default: begin
            s1_vld_d  = on_grid;
            s1_addr_d = on_grid ? pos_addr : 10'd0;
            s2_vld_d  = s1_vld_q;
            clr_d     = clr_q | (left_q == 10'd0);
            if (clearing) begin
               we      = 1'b1;
               waddr   = s2_addr_q;
               wdata   = 2'd0;
               eat_d   = 1'b1;
               pow_d   = (s2_cell_q == 2'd2);
               score_d = sum[16] ? 16'hFFFF : sum[15:0];
               left_d  = left_q - 10'd1;
            end
            if (Restart) begin
               state_d  = S_INIT;
               a_d      = '0;
               s1_vld_d = 1'b0;
               s2_vld_d = 1'b0;
               we       = 1'b0;
               eat_d    = 1'b0;
               pow_d    = 1'b0;
               score_d  = score_q;
               left_d   = '0;
               clr_d    = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= S_INIT;
         a_q       <= '0;
         ld_vld_q  <= 1'b0;
         ld_addr_q <= '0;
         s1_vld_q  <= 1'b0;
         s1_addr_q <= '0;
         s2_vld_q  <= 1'b0;
         s2_addr_q <= '0;
         s2_cell_q <= '0;
         score_q   <= '0;
         left_q    <= '0;
         eat_q     <= 1'b0;
         pow_q     <= 1'b0;
         clr_q     <= 1'b0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         ld_vld_q  <= ld_vld_d;
         ld_addr_q <= ld_addr_d;
         s1_vld_q  <= s1_vld_d;
         s1_addr_q <= s1_addr_d;
         s2_vld_q  <= s2_vld_d;
         s2_addr_q <= s2_addr_d;
         s2_cell_q <= s2_cell_d;
         score_q   <= score_d;
         left_q    <= left_d;
         eat_q     <= eat_d;
         pow_q     <= pow_d;
         clr_q     <= clr_d;
         rd_q      <= rd_d;
      end
   end

   always_ff @(posedge frame_clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign Rom_Addr     = (a_q < N10) ? a_q : (N10 - 10'd1);
   assign Rd_Data      = rd_q;
   assign Score        = score_q;
   assign Pellets_Left = left_q;
   assign Eat_Pulse    = eat_q;
   assign Power_Pulse  = pow_q;
   assign Level_Clear  = clr_q;
   assign Ready        = (state_q == S_RUN);

endmodule

// File: tb/tb_pellet_tracker.sv
// Directed bench for pellet_tracker: eat expectations are queued when the ball is placed and
// popped/compared whenever the DUT pulses Eat_Pulse.
module tb_pellet_tracker;

   logic        frame_clk = 1'b0;
   logic        Reset_n;
   logic [9:0]  BallX, BallY;
   logic        Restart;
   logic [9:0]  Rom_Addr;
   logic [1:0]  Rom_Data = 2'd0;
   logic [9:0]  Rd_Addr;
   logic [1:0]  Rd_Data;
   logic [15:0] Score;
   logic [9:0]  Pellets_Left;
   logic        Eat_Pulse, Power_Pulse, Level_Clear, Ready;

   logic [1:0]  rom [0:867];

   typedef struct packed {
      logic        pow;
      logic [15:0] score;
      logic [9:0]  left;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   eat_cnt = 0;
   int   pow_cnt = 0;

   always #5 frame_clk = ~frame_clk;
   always @(posedge frame_clk) Rom_Data <= rom[Rom_Addr];

   pellet_tracker dut (
      .frame_clk    (frame_clk),
      .Reset_n      (Reset_n),
      .BallX        (BallX),
      .BallY        (BallY),
      .Restart      (Restart),
      .Rom_Addr     (Rom_Addr),
      .Rom_Data     (Rom_Data),
      .Rd_Addr      (Rd_Addr),
      .Rd_Data      (Rd_Data),
      .Score        (Score),
      .Pellets_Left (Pellets_Left),
      .Eat_Pulse    (Eat_Pulse),
      .Power_Pulse  (Power_Pulse),
      .Level_Clear  (Level_Clear),
      .Ready        (Ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // one frame: edge, then sample; eat pulses are scored against the queue
   task automatic step();
      exp_t e;
      @(posedge frame_clk);
      #1;
      if (Power_Pulse === 1'b1) pow_cnt++;
      if (Eat_Pulse === 1'b1) begin
         eat_cnt++;
         check("eat_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("eat_power", Power_Pulse, e.pow);
            check("eat_score", Score, e.score);
            check("eat_left", Pellets_Left, e.left);
         end
      end
   endtask

   task automatic load(input string tag, input int exp_left);
      int n = 0;
      int bad = 0;
      while (Ready !== 1'b1 && n < 2000) begin
         step();
         n++;
         if (n < 868 && Rom_Addr !== 10'(n)) bad++;
      end
      check({tag, "_cycles"}, n, 869);
      check({tag, "_romaddr"}, bad, 0);
      check({tag, "_left"}, Pellets_Left, exp_left);
      check({tag, "_lvlclr"}, Level_Clear, 0);
   endtask

   task automatic fill_rom(input logic [1:0] v);
      for (int i = 0; i < 868; i++) rom[i] = v;
   endtask

   task automatic do_restart();
      Restart = 1'b1;
      step();
      Restart = 1'b0;
   endtask

   initial begin
      int e0, p0, n;
      logic [9:0] offx [4];
      logic [9:0] offy [4];
      offx = '{10'd100, 10'd440, 10'd236, 10'd236};
      offy = '{10'd60,  10'd60,  10'd8,   10'd264};

      Reset_n = 1'b0; Restart = 1'b0; BallX = '0; BallY = '0; Rd_Addr = '0;
      fill_rom(2'd1);
      repeat (3) step();
      check("rst_score", Score, 0);
      check("rst_left", Pellets_Left, 0);
      check("rst_eat", Eat_Pulse, 0);
      check("rst_power", Power_Pulse, 0);
      check("rst_lvlclr", Level_Clear, 0);
      check("rst_ready", Ready, 0);
      check("rst_romaddr", Rom_Addr, 0);
      check("rst_rddata", Rd_Data, 0);

      // all-pellet load
      Reset_n = 1'b1;
      load("load1", 868);
      check("load1_score", Score, 0);

      // eat at (236,60) -> cell 143, held 5 frames
      e0 = eat_cnt;
      BallX = 10'd236; BallY = 10'd60;
      exp_q.push_back(exp_t'{pow: 1'b0, score: 16'd10, left: 10'd867});
      step();
      step(); check("eat_k1_quiet", Eat_Pulse, 0);
      step(); check("eat_k2_pulse", Eat_Pulse, 1);
      step(); check("eat_k3_quiet", Eat_Pulse, 0);
      step();
      BallX = '0; BallY = '0;
      repeat (3) step();
      check("eat_once", eat_cnt - e0, 1);
      Rd_Addr = 10'd143; step(); check("rd_eaten", Rd_Data, 0);
      Rd_Addr = 10'd144; step(); check("rd_full", Rd_Data, 1);

      // rightmost on-grid column 27, cell 167
      e0 = eat_cnt;
      BallX = 10'd431; BallY = 10'd60;
      exp_q.push_back(exp_t'{pow: 1'b0, score: 16'd20, left: 10'd866});
      repeat (4) step();
      BallX = '0; BallY = '0;
      repeat (2) step();
      check("col27_eat", eat_cnt - e0, 1);

      // off-grid positions never eat
      e0 = eat_cnt;
      for (int i = 0; i < 4; i++) begin
         BallX = offx[i]; BallY = offy[i];
         repeat (4) step();
      end
      BallX = '0; BallY = '0;
      step();
      check("offgrid_no_eat", eat_cnt - e0, 0);
      check("offgrid_score", Score, 20);

      // power pellet at cell 0 after a restart; score carries over
      rom[0] = 2'd2;
      do_restart();
      check("restart_ready", Ready, 0);
      check("restart_romaddr", Rom_Addr, 0);
      load("load2", 868);
      check("load2_score", Score, 20);
      e0 = eat_cnt; p0 = pow_cnt;
      BallX = 10'd212; BallY = 10'd20;
      exp_q.push_back(exp_t'{pow: 1'b1, score: 16'd70, left: 10'd867});
      repeat (5) step();
      BallX = '0; BallY = '0;
      repeat (2) step();
      check("power_eat", eat_cnt - e0, 1);
      check("power_pulse", pow_cnt - p0, 1);

      // single-pellet map at cell 31 -> level clear
      fill_rom(2'd0);
      rom[31] = 2'd1;
      Reset_n = 1'b0; step(); Reset_n = 1'b1;
      load("load3", 1);
      BallX = 10'd236; BallY = 10'd28;
      exp_q.push_back(exp_t'{pow: 1'b0, score: 16'd10, left: 10'd0});
      step(); step(); step();
      check("lc_eat_edge", Eat_Pulse, 1);
      check("lc_not_yet", Level_Clear, 0);
      BallX = '0; BallY = '0;
      step(); check("lc_set", Level_Clear, 1);
      step(); check("lc_held", Level_Clear, 1);
      do_restart();
      check("lc_restart_ready", Ready, 0);
      check("lc_restart_clr", Level_Clear, 0);
      check("lc_restart_score", Score, 10);
      load("load4", 1);
      check("load4_score", Score, 10);

      // restart with an eat in flight: no pulse, no score
      e0 = eat_cnt;
      BallX = 10'd236; BallY = 10'd28;
      step();
      BallX = '0; BallY = '0;
      do_restart();
      load("load5", 1);
      check("flush_no_eat", eat_cnt - e0, 0);
      check("flush_score", Score, 10);

      // reset asserted mid-INIT at Rom_Addr 400
      fill_rom(2'd1);
      Reset_n = 1'b0; step(); Reset_n = 1'b1;
      n = 0;
      while (Rom_Addr !== 10'd400 && n < 1000) begin step(); n++; end
      check("midinit_reach400", Rom_Addr, 400);
      Reset_n = 1'b0;
      #1;
      check("midrst_romaddr", Rom_Addr, 0);
      check("midrst_ready", Ready, 0);
      check("midrst_score", Score, 0);
      check("midrst_left", Pellets_Left, 0);
      check("midrst_lvlclr", Level_Clear, 0);
      check("midrst_eat", Eat_Pulse, 0);
      check("midrst_rddata", Rd_Data, 0);
      step();
      Reset_n = 1'b1;
      load("load6", 868);

      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
